reg_xfer_decoder: RTL and testbench

REG_XFER_DECODER -- requirements
Module: reg_xfer_decoder

---
 rtl/reg_sel_pkg.sv | 46 ++++
 rtl/decoder_5_32.sv | 19 +
 rtl/reg_xfer_decoder.sv | 155 +++++++++++++++
 tb/tb_reg_xfer_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_sel_pkg.sv
// rtl/reg_sel_pkg.sv - register-code constants, state encoding and widths for the transfer decoder
// Purpose : shared definitions imported by decoder_5_32 and reg_xfer_decoder.
// Ports   : none (package).
// Config  : REG_XFER_ERR_EN adds the ERR state to the state encoding.
package reg_sel_pkg;

    localparam int CODE_W = 5;
    localparam int SEL_W  = 32;
    localparam int CNT_W  = 4;

    localparam logic [CODE_W-1:0] CODE_R0    = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R15   = 5'd15;
    localparam logic [CODE_W-1:0] CODE_HI    = 5'd16;
    localparam logic [CODE_W-1:0] CODE_LO    = 5'd17;
    localparam logic [CODE_W-1:0] CODE_ZHIGH = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZLOW  = 5'd19;
    localparam logic [CODE_W-1:0] CODE_PC    = 5'd20;
    localparam logic [CODE_W-1:0] CODE_MDR   = 5'd21;
    localparam logic [CODE_W-1:0] CODE_PORT  = 5'd22;
    localparam logic [CODE_W-1:0] CODE_SIGN  = 5'd23;
    localparam logic [CODE_W-1:0] CODE_NONE  = 5'd31;

    // First code with no physical register behind it; 24..30 are reserved.
    localparam logic [CODE_W-1:0] CODE_FIRST_RSVD = 5'd24;

`ifdef REG_XFER_ERR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_ERR   = 2'd3
    } xfer_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2
    } xfer_state_t;
`endif

    // Reserved codes are 24..30; 31 is the legal "none" code.
    function automatic logic is_reserved(input logic [CODE_W-1:0] code);
        return (code >= CODE_FIRST_RSVD) && (code != CODE_NONE);
    endfunction

endpackage

// File: rtl/decoder_5_32.sv
// rtl/decoder_5_32.sv - 5-bit register code to 32-bit one-hot select
// Purpose : combinational decode; codes 24..31 select nothing.
// Ports   : i_code   [4:0]  register code
//           o_onehot [31:0] one-hot select, all-zero for codes >= 24
import reg_sel_pkg::*;

module decoder_5_32 (
    input  logic [CODE_W-1:0] i_code,
    output logic [SEL_W-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_code < CODE_FIRST_RSVD) begin
            o_onehot[i_code] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_xfer_decoder.sv
// rtl/reg_xfer_decoder.sv - register-to-register bus transfer sequencer
// Purpose : accepts a src/dst code pair, drives the source onto the bus for
//           HOLD_CYCLES cycles, then latches it into the destination for one cycle.
// Ports   : clk, clr (sync active-high reset)
//           req_valid / req_ready  request handshake
//           src_code, dst_code     5-bit register codes
//           bus_sel, reg_en        32-bit one-hot drive / latch selects
//           busy, done             transfer in progress / completion pulse
//           err                    reserved-code pulse (REG_XFER_ERR_EN only)
// Config  : REG_XFER_ERR_EN enables the ERR state and err port.
import reg_sel_pkg::*;

module reg_xfer_decoder #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] src_code,
    input  logic [CODE_W-1:0] dst_code,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [SEL_W-1:0]  reg_en,
    output logic              busy,
    output logic              done
`ifdef REG_XFER_ERR_EN
    ,
    output logic              err
`endif
);

    localparam logic [CNT_W-1:0] HOLD_N = HOLD_CYCLES[CNT_W-1:0];

    xfer_state_t       r_state;
    logic [CODE_W-1:0] r_src;
    logic [CODE_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_bus_sel;
    logic [SEL_W-1:0]  r_reg_en;
    logic              r_busy;
    logic              r_done;
`ifdef REG_XFER_ERR_EN
    logic              r_err;
`endif

    logic [CODE_W-1:0] w_src_code;
    logic [CODE_W-1:0] w_dst_code;
    logic [SEL_W-1:0]  w_src_oh;
    logic [SEL_W-1:0]  w_dst_oh;

    // In IDLE the decoders look at the live inputs so the DRIVE select can be
    // registered on the accept edge; afterwards they hold the captured codes.
    assign w_src_code = (r_state == ST_IDLE) ? src_code : r_src;
    assign w_dst_code = (r_state == ST_IDLE) ? dst_code : r_dst;

    decoder_5_32 u_src_dec (
        .i_code   (w_src_code),
        .o_onehot (w_src_oh)
    );

    decoder_5_32 u_dst_dec (
        .i_code   (w_dst_code),
        .o_onehot (w_dst_oh)
    );

    // Ready is gated by clr so it drops during reset and rises the first
    // cycle clr is low.
    assign req_ready = (r_state == ST_IDLE) && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_bus_sel <= '0;
            r_reg_en  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef REG_XFER_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bus_sel <= '0;
                    r_reg_en  <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_cnt     <= '0;
                    if (req_valid) begin
                        r_src  <= src_code;
                        r_dst  <= dst_code;
                        r_busy <= 1'b1;
`ifdef REG_XFER_ERR_EN
                        if (is_reserved(src_code) || is_reserved(dst_code)) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= ST_DRIVE;
                            r_cnt     <= 4'd1;
                            r_bus_sel <= w_src_oh;
                        end
`else
                        r_state   <= ST_DRIVE;
                        r_cnt     <= 4'd1;
                        r_bus_sel <= w_src_oh;
`endif
                    end
                end
                ST_DRIVE: begin
                    r_bus_sel <= w_src_oh;
                    if (r_cnt == HOLD_N) begin
                        r_state  <= ST_LATCH;
                        r_reg_en <= w_dst_oh;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_LATCH: begin
                    r_state   <= ST_IDLE;
                    r_bus_sel <= '0;
                    r_reg_en  <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_cnt     <= '0;
                end
`ifdef REG_XFER_ERR_EN
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_sel <= '0;
                    r_reg_en  <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_sel = r_bus_sel;
    assign reg_en  = r_reg_en;
    assign busy    = r_busy;
    assign done    = r_done;
`ifdef REG_XFER_ERR_EN
    assign err     = r_err;
`endif

endmodule

// File: tb/tb_reg_xfer_decoder.sv
// tb/tb_reg_xfer_decoder.sv - directed self-checking bench for reg_xfer_decoder
module tb_reg_xfer_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with HOLD_CYCLES = 1
    logic        clr1, v1, rdy1, busy1, done1;
    logic [4:0]  s1, d1;
    logic [31:0] bus1, en1;
    // Instance with HOLD_CYCLES = 3
    logic        clr3, v3, rdy3, busy3, done3;
    logic [4:0]  s3, d3;
    logic [31:0] bus3, en3;
`ifdef REG_XFER_ERR_EN
    logic        err1, err3;
`endif

    int checks = 0;
    int errors = 0;

    reg_xfer_decoder #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .clr(clr1), .req_valid(v1), .req_ready(rdy1),
        .src_code(s1), .dst_code(d1), .bus_sel(bus1), .reg_en(en1),
        .busy(busy1), .done(done1)
`ifdef REG_XFER_ERR_EN
        , .err(err1)
`endif
    );

    reg_xfer_decoder #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .clr(clr3), .req_valid(v3), .req_ready(rdy3),
        .src_code(s3), .dst_code(d3), .bus_sel(bus3), .reg_en(en3),
        .busy(busy3), .done(done3)
`ifdef REG_XFER_ERR_EN
        , .err(err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic rdy, input logic [31:0] bus,
                        input logic [31:0] en, input logic bsy, input logic dn);
        check({tag, ".ready"}, {31'd0, rdy1}, {31'd0, rdy});
        check({tag, ".bus_sel"}, bus1, bus);
        check({tag, ".reg_en"}, en1, en);
        check({tag, ".busy"}, {31'd0, busy1}, {31'd0, bsy});
        check({tag, ".done"}, {31'd0, done1}, {31'd0, dn});
    endtask

    task automatic chk3(input string tag, input logic rdy, input logic [31:0] bus,
                        input logic [31:0] en, input logic bsy, input logic dn);
        check({tag, ".ready"}, {31'd0, rdy3}, {31'd0, rdy});
        check({tag, ".bus_sel"}, bus3, bus);
        check({tag, ".reg_en"}, en3, en);
        check({tag, ".busy"}, {31'd0, busy3}, {31'd0, bsy});
        check({tag, ".done"}, {31'd0, done3}, {31'd0, dn});
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr1 = 1'b1; v1 = 1'b0; s1 = 5'd0; d1 = 5'd0;
        clr3 = 1'b1; v3 = 1'b0; s3 = 5'd0; d3 = 5'd0;
        tick();
        tick();
        chk1("rst1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk3("rst3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        clr1 = 1'b0; clr3 = 1'b0;
        #1;
        chk1("rst1_rel", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk3("rst3_rel", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // pc -> mdr, HOLD_CYCLES = 1
        v1 = 1'b1; s1 = 5'd20; d1 = 5'd21;
        tick(); v1 = 1'b0;
        chk1("pc_mdr.drive", 1'b0, 32'h0010_0000, 32'h0, 1'b1, 1'b0);
        tick();
        chk1("pc_mdr.latch", 1'b0, 32'h0010_0000, 32'h0020_0000, 1'b1, 1'b1);
        tick();
        chk1("pc_mdr.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // src none -> r4
        v1 = 1'b1; s1 = 5'd31; d1 = 5'd4;
        tick(); v1 = 1'b0;
        chk1("none_r4.drive", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk1("none_r4.latch", 1'b0, 32'h0, 32'h0000_0010, 1'b1, 1'b1);
        tick();
        chk1("none_r4.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // reserved src 26 -> r4
        v1 = 1'b1; s1 = 5'd26; d1 = 5'd4;
        tick(); v1 = 1'b0;
`ifdef REG_XFER_ERR_EN
        chk1("rsvd.err", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("rsvd.err_pulse", {31'd0, err1}, 32'd1);
        tick();
        chk1("rsvd.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rsvd.err_clear", {31'd0, err1}, 32'd0);
`else
        chk1("rsvd.drive", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk1("rsvd.latch", 1'b0, 32'h0, 32'h0000_0010, 1'b1, 1'b1);
        tick();
        chk1("rsvd.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
`endif

        // req_valid held, codes change while busy
        v1 = 1'b1; s1 = 5'd1; d1 = 5'd2;
        tick(); s1 = 5'd5; d1 = 5'd6;
        chk1("hold.drive", 1'b0, 32'h0000_0002, 32'h0, 1'b1, 1'b0);
        tick();
        chk1("hold.latch", 1'b0, 32'h0000_0002, 32'h0000_0004, 1'b1, 1'b1);
        tick();
        chk1("hold.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); v1 = 1'b0;
        chk1("hold2.drive", 1'b0, 32'h0000_0020, 32'h0, 1'b1, 1'b0);
        tick();
        chk1("hold2.latch", 1'b0, 32'h0000_0020, 32'h0000_0040, 1'b1, 1'b1);
        tick();
        chk1("hold2.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // HOLD_CYCLES = 3, r0 -> r15, back-to-back
        v3 = 1'b1; s3 = 5'd0; d3 = 5'd15;
        tick();
        chk3("h3.drive1", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3.drive2", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3.drive3", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3.latch", 1'b0, 32'h1, 32'h0000_8000, 1'b1, 1'b1);
        tick();
        chk3("h3.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); v3 = 1'b0;
        chk3("h3b.drive1", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3b.drive2", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3b.drive3", 1'b0, 32'h1, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("h3b.latch", 1'b0, 32'h1, 32'h0000_8000, 1'b1, 1'b1);
        tick();
        chk3("h3b.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        // clr during 2nd DRIVE cycle aborts without done
        v3 = 1'b1; s3 = 5'd3; d3 = 5'd7;
        tick(); v3 = 1'b0;
        chk3("abort.drive1", 1'b0, 32'h0000_0008, 32'h0, 1'b1, 1'b0);
        tick();
        chk3("abort.drive2", 1'b0, 32'h0000_0008, 32'h0, 1'b1, 1'b0);
        clr3 = 1'b1;
        tick();
        chk3("abort.clr", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        clr3 = 1'b0;
        #1;
        check("abort.ready", {31'd0, rdy3}, 32'd1);
        tick();
        chk3("abort.idle", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk3("abort.idle2", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
